// File: rtl/axi_sram_slave.sv
// AXI3 responder backed by a word-addressed SRAM array.
// Independent read and write FSMs share the array, so one burst of each can be in flight at once.
module axi_sram_slave #(
  parameter int ID_W   = 4,
  parameter int ADDR_W = 32,
  parameter int MEM_AW = 12
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic [ID_W-1:0]   arid,
  input  logic [ADDR_W-1:0] araddr,
  input  logic [3:0]        arlen,
  input  logic [2:0]        arsize,
  input  logic [1:0]        arburst,
  input  logic [1:0]        arlock,
  input  logic [3:0]        arcache,
  input  logic [2:0]        arprot,
  input  logic              arvalid,
  output logic              arready,
  output logic [ID_W-1:0]   rid,
  output logic [31:0]       rdata,
  output logic [1:0]        rresp,
  output logic              rlast,
  output logic              rvalid,
  input  logic              rready,
  input  logic [ID_W-1:0]   awid,
  input  logic [ADDR_W-1:0] awaddr,
  input  logic [3:0]        awlen,
  input  logic [2:0]        awsize,
  input  logic [1:0]        awburst,
  input  logic [1:0]        awlock,
  input  logic [3:0]        awcache,
  input  logic [2:0]        awprot,
  input  logic              awvalid,
  output logic              awready,
  input  logic [ID_W-1:0]   wid,
  input  logic [31:0]       wdata,
  input  logic [3:0]        wstrb,
  input  logic              wlast,
  input  logic              wvalid,
  output logic              wready,
  output logic [ID_W-1:0]   bid,
  output logic [1:0]        bresp,
  output logic              bvalid,
  input  logic              bready
);

  localparam int DEPTH = 1 << MEM_AW;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {R_IDLE, R_DATA} rState_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wState_t;

  logic [31:0] mem [DEPTH];

  logic unusedInputs;
  assign unusedInputs = ^{arlock, arcache, arprot, awlock, awcache, awprot, wid};

  // Read channel state
  rState_t rState_q, rState_d;
  logic arready_q, arready_d, rvalid_q, rvalid_d, rlast_q, rlast_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0] rresp_q, rresp_d;
  logic [ID_W-1:0] rid_q, rid_d;
  logic [ADDR_W-1:0] rAddr_q, rAddr_d, rAddrNext, rStep;
  logic [3:0] rLen_q, rLen_d, rCnt_q, rCnt_d;
  logic [2:0] rSize_q, rSize_d;
  logic [1:0] rBurst_q, rBurst_d;
  logic rBad_q, rBad_d;
  logic arHs, rHs;

  // Write channel state
  wState_t wState_q, wState_d;
  logic awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
  logic [ID_W-1:0] bid_q, bid_d, wId_q, wId_d;
  logic [1:0] bresp_q, bresp_d;
  logic [ADDR_W-1:0] wAddr_q, wAddr_d, wAddrNext, wStep;
  logic [3:0] wLen_q, wLen_d, wCnt_q, wCnt_d;
  logic [2:0] wSize_q, wSize_d;
  logic [1:0] wBurst_q, wBurst_d;
  logic wBad_q, wBad_d, wErr_q, wErr_d;
  logic awHs, wHs, wFinal, memWe;

  assign arHs = arready_q & arvalid;
  assign rHs  = rvalid_q & rready;
  assign awHs = awready_q & awvalid;
  assign wHs  = wready_q & wvalid;

  // FIXED holds the address; INCR and WRAP both advance by the beat size.
  assign rStep     = (rBurst_q == 2'b00) ? '0 : (ADDR_W'(1) << rSize_q);
  assign rAddrNext = rAddr_q + rStep;
  assign wStep     = (wBurst_q == 2'b00) ? '0 : (ADDR_W'(1) << wSize_q);
  assign wAddrNext = wAddr_q + wStep;
  assign wFinal    = (wCnt_q == wLen_q);
  assign memWe     = (wState_q == W_DATA) & wHs & ~wBad_q;

  always_comb begin
    rState_d  = rState_q;
    arready_d = arready_q;
    rvalid_d  = rvalid_q;
    rlast_d   = rlast_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    rid_d     = rid_q;
    rAddr_d   = rAddr_q;
    rLen_d    = rLen_q;
    rCnt_d    = rCnt_q;
    rSize_d   = rSize_q;
    rBurst_d  = rBurst_q;
    rBad_d    = rBad_q;
    case (rState_q)
      R_IDLE: begin
        arready_d = 1'b1;
        if (arHs) begin
          rid_d     = arid;
          rAddr_d   = araddr;
          rLen_d    = arlen;
          rSize_d   = arsize;
          rBurst_d  = arburst;
          rCnt_d    = '0;
          rBad_d    = (arsize > 3'd2);
          rdata_d   = (arsize > 3'd2) ? 32'h0 : mem[araddr[MEM_AW+1:2]];
          rresp_d   = (arsize > 3'd2) ? RESP_SLVERR : RESP_OKAY;
          rlast_d   = (arlen == 4'd0);
          rvalid_d  = 1'b1;
          arready_d = 1'b0;
          rState_d  = R_DATA;
        end
      end
      R_DATA: begin
        arready_d = 1'b0;
        if (rHs) begin
          if (rlast_q) begin
            rvalid_d  = 1'b0;
            rlast_d   = 1'b0;
            arready_d = 1'b1;
            rState_d  = R_IDLE;
          end else begin
            rCnt_d  = rCnt_q + 4'd1;
            rAddr_d = rAddrNext;
            rdata_d = rBad_q ? 32'h0 : mem[rAddrNext[MEM_AW+1:2]];
            rlast_d = ((rCnt_q + 4'd1) == rLen_q);
          end
        end
      end
      default: rState_d = R_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rState_q  <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= '0;
      rid_q     <= '0;
      rAddr_q   <= '0;
      rLen_q    <= '0;
      rCnt_q    <= '0;
      rSize_q   <= '0;
      rBurst_q  <= '0;
      rBad_q    <= 1'b0;
    end else begin
      rState_q  <= rState_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rlast_q   <= rlast_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      rid_q     <= rid_d;
      rAddr_q   <= rAddr_d;
      rLen_q    <= rLen_d;
      rCnt_q    <= rCnt_d;
      rSize_q   <= rSize_d;
      rBurst_q  <= rBurst_d;
      rBad_q    <= rBad_d;
    end
  end

  always_comb begin
    wState_d  = wState_q;
    awready_d = awready_q;
    wready_d  = wready_q;
    bvalid_d  = bvalid_q;
    bid_d     = bid_q;
    bresp_d   = bresp_q;
    wId_d     = wId_q;
    wAddr_d   = wAddr_q;
    wLen_d    = wLen_q;
    wCnt_d    = wCnt_q;
    wSize_d   = wSize_q;
    wBurst_d  = wBurst_q;
    wBad_d    = wBad_q;
    wErr_d    = wErr_q;
    case (wState_q)
      W_IDLE: begin
        awready_d = 1'b1;
        if (awHs) begin
          wId_d     = awid;
          wAddr_d   = awaddr;
          wLen_d    = awlen;
          wSize_d   = awsize;
          wBurst_d  = awburst;
          wCnt_d    = '0;
          wBad_d    = (awsize > 3'd2);
          wErr_d    = 1'b0;
          awready_d = 1'b0;
          wready_d  = 1'b1;
          wState_d  = W_DATA;
        end
      end
      // Burst length comes from awlen; wlast only flags a protocol error.
      W_DATA: begin
        if (wHs) begin
          if (wFinal) begin
            wready_d = 1'b0;
            bvalid_d = 1'b1;
            bid_d    = wId_q;
            bresp_d  = (wBad_q | wErr_q | ~wlast) ? RESP_SLVERR : RESP_OKAY;
            wState_d = W_RESP;
          end else begin
            wCnt_d  = wCnt_q + 4'd1;
            wAddr_d = wAddrNext;
            wErr_d  = wErr_q | wlast;
          end
        end
      end
      W_RESP: begin
        if (bvalid_q & bready) begin
          bvalid_d  = 1'b0;
          awready_d = 1'b1;
          wState_d  = W_IDLE;
        end
      end
      default: wState_d = W_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wState_q  <= W_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bid_q     <= '0;
      bresp_q   <= '0;
      wId_q     <= '0;
      wAddr_q   <= '0;
      wLen_q    <= '0;
      wCnt_q    <= '0;
      wSize_q   <= '0;
      wBurst_q  <= '0;
      wBad_q    <= 1'b0;
      wErr_q    <= 1'b0;
    end else begin
      wState_q  <= wState_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bid_q     <= bid_d;
      bresp_q   <= bresp_d;
      wId_q     <= wId_d;
      wAddr_q   <= wAddr_d;
      wLen_q    <= wLen_d;
      wCnt_q    <= wCnt_d;
      wSize_q   <= wSize_d;
      wBurst_q  <= wBurst_d;
      wBad_q    <= wBad_d;
      wErr_q    <= wErr_d;
    end
  end

  // Array has no reset; a same-edge read sees the old word since both sides are registered.
  always_ff @(posedge aclk) begin
    if (memWe) begin
      for (int i = 0; i < 4; i++) begin
        if (wstrb[i]) mem[wAddr_q[MEM_AW+1:2]][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign arready = arready_q;
  assign rvalid  = rvalid_q;
  assign rlast   = rlast_q;
  assign rdata   = rdata_q;
  assign rresp   = rresp_q;
  assign rid     = rid_q;
  assign awready = awready_q;
  assign wready  = wready_q;
  assign bvalid  = bvalid_q;
  assign bid     = bid_q;
  assign bresp   = bresp_q;

endmodule

// File: tb/tb_axi_sram_slave.sv
// Directed self-checking bench for axi_sram_slave: writes, bursts, strobes, errors and reset.
`timescale 1ns/1ps
module tb_axi_sram_slave;

  logic aclk, aresetn;
  logic [3:0] arid, awid, wid, rid, bid;
  logic [31:0] araddr, awaddr, wdata, rdata;
  logic [3:0] arlen, awlen, arcache, awcache, wstrb;
  logic [2:0] arsize, awsize, arprot, awprot;
  logic [1:0] arburst, awburst, arlock, awlock, rresp, bresp;
  logic arvalid, arready, rlast, rvalid, rready;
  logic awvalid, awready, wlast, wvalid, wready, bvalid, bready;

  int checkCount = 0;
  int passCount  = 0;

  axi_sram_slave #(.ID_W(4), .ADDR_W(32), .MEM_AW(12)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
  endtask

  function automatic logic sigVal(input int sel);
    case (sel)
      0: return awready;
      1: return wready;
      2: return bvalid;
      3: return arready;
      default: return rvalid;
    endcase
  endfunction

  // Bounded wait; a timeout is reported as a failed comparison.
  task automatic waitSig(input int sel, input string tag);
    int n = 0;
    while (sigVal(sel) !== 1'b1 && n < 100) begin
      @(posedge aclk); #1;
      n++;
    end
    if (sigVal(sel) !== 1'b1) checkOutput({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic writeBurst(input logic [3:0] id, input logic [31:0] addr, input int len,
                            input logic [2:0] size, input logic [1:0] burst,
                            input logic [31:0] d0, input logic [31:0] d1,
                            input logic [31:0] d2, input logic [31:0] d3,
                            input logic [3:0] strb, input bit earlyLast,
                            input logic [1:0] expResp, input string tag);
    logic [31:0] d [4];
    d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
    awid = id; awaddr = addr; awlen = 4'(len); awsize = size; awburst = burst; awvalid = 1'b1;
    waitSig(0, {tag, "_aw"});
    @(posedge aclk); #1;
    awvalid = 1'b0;
    for (int i = 0; i <= len; i++) begin
      wdata = d[i]; wstrb = strb;
      wlast = (i == len) || (earlyLast && i == 0);
      wvalid = 1'b1;
      waitSig(1, {tag, "_w"});
      @(posedge aclk); #1;
    end
    wvalid = 1'b0; wlast = 1'b0;
    checkOutput({tag, "_bvalid_lat"}, 32'(bvalid), 32'd1);
    bready = 1'b1;
    waitSig(2, {tag, "_b"});
    checkOutput({tag, "_bresp"}, 32'(bresp), 32'(expResp));
    checkOutput({tag, "_bid"}, 32'(bid), 32'(id));
    @(posedge aclk); #1;
    bready = 1'b0;
  endtask

  task automatic applyStimulus(input logic [3:0] id, input logic [31:0] addr, input int len,
                               input logic [2:0] size, input logic [1:0] burst, input string tag);
    arid = id; araddr = addr; arlen = 4'(len); arsize = size; arburst = burst; arvalid = 1'b1;
    waitSig(3, {tag, "_ar"});
    @(posedge aclk); #1;
    arvalid = 1'b0;
    checkOutput({tag, "_rvalid_lat"}, 32'(rvalid), 32'd1);
  endtask

  task automatic readBeat(input logic [31:0] expData, input logic [1:0] expResp, input bit expLast,
                          input logic [3:0] expId, input bit stall, input string tag);
    waitSig(4, {tag, "_r"});
    if (stall) begin
      rready = 1'b0;
      @(posedge aclk); #1;
      checkOutput({tag, "_stall_data"}, rdata, expData);
    end
    checkOutput({tag, "_data"}, rdata, expData);
    checkOutput({tag, "_resp"}, 32'(rresp), 32'(expResp));
    checkOutput({tag, "_last"}, 32'(rlast), 32'(expLast));
    checkOutput({tag, "_rid"}, 32'(rid), 32'(expId));
    checkOutput({tag, "_arready"}, 32'(arready), 32'd0);
    rready = 1'b1;
    @(posedge aclk); #1;
    rready = 1'b0;
  endtask

  task automatic clearInputs();
    arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0;
    arlock = '0; arcache = '0; arprot = '0; arvalid = 1'b0; rready = 1'b0;
    awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0;
    awlock = '0; awcache = '0; awprot = '0; awvalid = 1'b0;
    wid = '0; wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
  endtask

  initial begin
    clearInputs();
    aresetn = 1'b0;
    repeat (3) @(posedge aclk);
    #1;
    checkOutput("rst_arready", 32'(arready), 32'd0);
    checkOutput("rst_awready", 32'(awready), 32'd0);
    checkOutput("rst_wready", 32'(wready), 32'd0);
    checkOutput("rst_rvalid", 32'(rvalid), 32'd0);
    checkOutput("rst_bvalid", 32'(bvalid), 32'd0);
    checkOutput("rst_rdata", rdata, 32'd0);
    aresetn = 1'b1;
    @(posedge aclk); #1;
    checkOutput("rel_arready", 32'(arready), 32'd1);
    checkOutput("rel_awready", 32'(awready), 32'd1);

    // Single write then single read
    writeBurst(4'd5, 32'h100, 0, 3'd2, 2'b01, 32'hDEADBEEF, 0, 0, 0, 4'hF, 1'b0, 2'b00, "single_wr");
    applyStimulus(4'd3, 32'h100, 0, 3'd2, 2'b01, "single_rd");
    readBeat(32'hDEADBEEF, 2'b00, 1'b1, 4'd3, 1'b0, "single_rd_b0");
    checkOutput("single_rd_done_rvalid", 32'(rvalid), 32'd0);
    checkOutput("single_rd_done_arready", 32'(arready), 32'd1);

    // INCR burst with stalls on alternate beats
    writeBurst(4'd2, 32'h200, 3, 3'd2, 2'b01, 32'd1, 32'd2, 32'd3, 32'd4, 4'hF, 1'b0, 2'b00, "incr_wr");
    applyStimulus(4'd7, 32'h200, 3, 3'd2, 2'b01, "incr_rd");
    for (int i = 0; i < 4; i++)
      readBeat(32'(i + 1), 2'b00, (i == 3), 4'd7, (i % 2 == 0), $sformatf("incr_rd_b%0d", i));

    // Partial byte strobes
    writeBurst(4'd1, 32'h300, 0, 3'd2, 2'b01, 32'h11223344, 0, 0, 0, 4'hF, 1'b0, 2'b00, "strb_pre");
    writeBurst(4'd1, 32'h300, 0, 3'd2, 2'b01, 32'hAABBCCDD, 0, 0, 0, 4'b0101, 1'b0, 2'b00, "strb_wr");
    applyStimulus(4'd1, 32'h300, 0, 3'd2, 2'b01, "strb_rd");
    readBeat(32'h11BB33DD, 2'b00, 1'b1, 4'd1, 1'b0, "strb_rd_b0");

    // FIXED read repeats the same word
    applyStimulus(4'd4, 32'h200, 2, 3'd2, 2'b00, "fixed_rd");
    for (int i = 0; i < 3; i++)
      readBeat(32'd1, 2'b00, (i == 2), 4'd4, 1'b0, $sformatf("fixed_rd_b%0d", i));

    // INCR past the top word wraps to word 0
    writeBurst(4'd6, 32'h3FFC, 1, 3'd2, 2'b01, 32'hA5A5_0001, 32'h5A5A_0002, 0, 0, 4'hF, 1'b0, 2'b00, "top_wr");
    applyStimulus(4'd6, 32'h3FFC, 0, 3'd2, 2'b01, "top_rd");
    readBeat(32'hA5A5_0001, 2'b00, 1'b1, 4'd6, 1'b0, "top_rd_b0");
    applyStimulus(4'd6, 32'h0, 0, 3'd2, 2'b01, "wrap_rd");
    readBeat(32'h5A5A_0002, 2'b00, 1'b1, 4'd6, 1'b0, "wrap_rd_b0");

    // Oversized write is rejected and leaves the array alone
    writeBurst(4'd9, 32'h100, 0, 3'd3, 2'b01, 32'h12345678, 0, 0, 0, 4'hF, 1'b0, 2'b10, "bad_wr");
    applyStimulus(4'd9, 32'h100, 0, 3'd2, 2'b01, "bad_wr_rd");
    readBeat(32'hDEADBEEF, 2'b00, 1'b1, 4'd9, 1'b0, "bad_wr_rd_b0");
    applyStimulus(4'd8, 32'h100, 0, 3'd3, 2'b01, "bad_rd");
    readBeat(32'h0, 2'b10, 1'b1, 4'd8, 1'b0, "bad_rd_b0");

    // Early wlast still writes both beats but flags SLVERR
    writeBurst(4'd3, 32'h400, 1, 3'd2, 2'b01, 32'h55, 32'h66, 0, 0, 4'hF, 1'b1, 2'b10, "early_wr");
    applyStimulus(4'd3, 32'h400, 1, 3'd2, 2'b01, "early_rd");
    readBeat(32'h55, 2'b00, 1'b0, 4'd3, 1'b0, "early_rd_b0");
    readBeat(32'h66, 2'b00, 1'b1, 4'd3, 1'b0, "early_rd_b1");

    // Reset during beat 2 of an 8-beat read
    applyStimulus(4'd2, 32'h200, 7, 3'd2, 2'b01, "rst_rd");
    readBeat(32'd1, 2'b00, 1'b0, 4'd2, 1'b0, "rst_rd_b0");
    readBeat(32'd2, 2'b00, 1'b0, 4'd2, 1'b0, "rst_rd_b1");
    waitSig(4, "rst_rd_b2");
    aresetn = 1'b0;
    clearInputs();
    #1;
    checkOutput("midrst_rvalid", 32'(rvalid), 32'd0);
    checkOutput("midrst_rdata", rdata, 32'd0);
    @(posedge aclk); #1;
    aresetn = 1'b1;
    checkOutput("midrst_hold_arready", 32'(arready), 32'd0);
    @(posedge aclk); #1;
    checkOutput("midrst_rel_arready", 32'(arready), 32'd1);
    checkOutput("midrst_rel_rvalid", 32'(rvalid), 32'd0);
    applyStimulus(4'd5, 32'h100, 0, 3'd2, 2'b01, "post_rst_rd");
    readBeat(32'hDEADBEEF, 2'b00, 1'b1, 4'd5, 1'b0, "post_rst_rd_b0");

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
